// File: rtl/tx_fc_credit_gate_pkg.sv
// Shared types for the transmit flow-control gate: command/result/type encodings,
// FSM states and the command-to-credit-requirement decoder.
package Tx_Arbiter_Package;

    typedef enum logic [2:0] {
        FC_NOP    = 3'd0,
        FC_P_H    = 3'd1,
        FC_P_HD   = 3'd2,
        FC_NP_H   = 3'd3,
        FC_NP_HD  = 3'd4,
        FC_CPL_H  = 3'd5,
        FC_CPL_HD = 3'd6
    } FC_command_t;

    typedef enum logic [1:0] {
        FC_FAILED    = 2'd0,
        FC_SUCCESS_1 = 2'd1,
        FC_SUCCESS_2 = 2'd2
    } FC_result_t;

    typedef enum logic [1:0] {
        FC_TYPE_P   = 2'd0,
        FC_TYPE_NP  = 2'd1,
        FC_TYPE_CPL = 2'd2
    } fc_type_t;

    typedef enum logic {
        S_INIT   = 1'b0,
        S_ACTIVE = 1'b1
    } fc_state_t;

    localparam int FC_NUM_TYPES = 3;
    localparam int FC_NUM_CANDS = 2;
    localparam int FC_PTLP_W    = 10;
    localparam int FC_DREQ_W    = 9;

    typedef struct packed {
        logic                 valid;
        fc_type_t             ftype;
        logic [FC_DREQ_W-1:0] data_req;
    } fc_req_t;

    // Header need is implicit (always one credit when valid); data need is
    // ceil(len/4) credits for *_HD, where a zero length encodes 1024 DW.
    function automatic fc_req_t fc_decode(input FC_command_t cmd,
                                          input logic [FC_PTLP_W-1:0] ptlp);
        fc_req_t              r;
        logic                 has_data;
        logic [FC_PTLP_W:0]   rounded;
        r.valid    = 1'b1;
        r.ftype    = FC_TYPE_P;
        r.data_req = '0;
        has_data   = 1'b0;
        rounded    = {1'b0, ptlp} + 11'd3;
        case (cmd)
            FC_P_H:    r.ftype = FC_TYPE_P;
            FC_P_HD:   begin r.ftype = FC_TYPE_P;   has_data = 1'b1; end
            FC_NP_H:   r.ftype = FC_TYPE_NP;
            FC_NP_HD:  begin r.ftype = FC_TYPE_NP;  has_data = 1'b1; end
            FC_CPL_H:  r.ftype = FC_TYPE_CPL;
            FC_CPL_HD: begin r.ftype = FC_TYPE_CPL; has_data = 1'b1; end
            default:   r.valid = 1'b0;
        endcase
        if (has_data) begin
            r.data_req = (ptlp == '0) ? 9'd256 : rounded[FC_PTLP_W:2];
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_fc_credit_gate_type_tracker.sv
// Credit state for one FC type: limits, consumed counters, infinite flags and
// the modular pass check for each candidate aimed at this type.
module tx_fc_type_tracker
    import Tx_Arbiter_Package::*;
#(
    parameter int HDR_W  = 12,
    parameter int DATA_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   init_i,
    input  logic                                   update_i,
    input  logic [HDR_W-1:0]                       hdr_val_i,
    input  logic [DATA_W-1:0]                      data_val_i,
    input  logic [FC_NUM_CANDS-1:0]                hit_i,
    input  logic [FC_NUM_CANDS-1:0][FC_DREQ_W-1:0] data_req_i,
    input  logic                                   consume_i,
    input  logic [FC_DREQ_W-1:0]                   consume_data_i,
    output logic [FC_NUM_CANDS-1:0]                pass_o
);

    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

    logic [HDR_W-1:0]  cl_hdr_q,  cl_hdr_d;
    logic [HDR_W-1:0]  cc_hdr_q,  cc_hdr_d;
    logic [DATA_W-1:0] cl_data_q, cl_data_d;
    logic [DATA_W-1:0] cc_data_q, cc_data_d;
    logic              inf_hdr_q,  inf_hdr_d;
    logic              inf_data_q, inf_data_d;

    logic [HDR_W-1:0]  hdr_margin;
    logic              hdr_ok;

    // Limit reload and consumption are independent; both look at the
    // pre-edge infinite flags.
    always_comb begin
        cl_hdr_d   = cl_hdr_q;
        cc_hdr_d   = cc_hdr_q;
        cl_data_d  = cl_data_q;
        cc_data_d  = cc_data_q;
        inf_hdr_d  = inf_hdr_q;
        inf_data_d = inf_data_q;
        if (init_i) begin
            cl_hdr_d   = hdr_val_i;
            cl_data_d  = data_val_i;
            inf_hdr_d  = (hdr_val_i == '0);
            inf_data_d = (data_val_i == '0);
        end else if (update_i) begin
            if (!inf_hdr_q)  cl_hdr_d  = hdr_val_i;
            if (!inf_data_q) cl_data_d = data_val_i;
        end
        if (consume_i) begin
            if (!inf_hdr_q)  cc_hdr_d  = cc_hdr_q + HDR_W'(1);
            if (!inf_data_q) cc_data_d = cc_data_q + DATA_W'(consume_data_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cl_hdr_q   <= '0;
            cc_hdr_q   <= '0;
            cl_data_q  <= '0;
            cc_data_q  <= '0;
            inf_hdr_q  <= 1'b0;
            inf_data_q <= 1'b0;
        end else begin
            cl_hdr_q   <= cl_hdr_d;
            cc_hdr_q   <= cc_hdr_d;
            cl_data_q  <= cl_data_d;
            cc_data_q  <= cc_data_d;
            inf_hdr_q  <= inf_hdr_d;
            inf_data_q <= inf_data_d;
        end
    end

    assign hdr_margin = cl_hdr_q - cc_hdr_q - HDR_W'(1);
    assign hdr_ok     = inf_hdr_q || (hdr_margin <= HDR_HALF);

    genvar gi;
    generate
        for (gi = 0; gi < FC_NUM_CANDS; gi++) begin : g_cand
            logic [DATA_W-1:0] data_margin;
            assign data_margin = cl_data_q - cc_data_q - DATA_W'(data_req_i[gi]);
            assign pass_o[gi]  = hit_i[gi] && hdr_ok &&
                                 (inf_data_q || (data_margin <= DATA_HALF));
        end
    endgenerate

endmodule

// File: rtl/tx_fc_credit_gate.sv
// Transmit flow-control gate: tracks P/NP/CPL credits advertised by the link
// partner and grants at most one of two candidate TLPs per cycle.
module tx_fc_credit_gate
    import Tx_Arbiter_Package::*;
#(
    parameter int FC_HDR_WIDTH  = 12,
    parameter int FC_DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FC_PTLP_W-1:0]     PTLP_1,
    input  logic [FC_PTLP_W-1:0]     PTLP_2,
    input  FC_command_t              Command_1,
    input  FC_command_t              Command_2,
    output FC_result_t               Result,
    input  logic                     DLL_FC_valid,
    input  logic                     DLL_FC_init,
    input  fc_type_t                 DLL_FC_type,
    input  logic [FC_HDR_WIDTH-1:0]  DLL_FC_hdr,
    input  logic [FC_DATA_WIDTH-1:0] DLL_FC_data,
    output logic                     FC_ready
);

    fc_state_t                  state_q, state_d;
    logic [FC_NUM_TYPES-1:0]    init_mask_q, init_mask_d;
    FC_result_t                 result_q, result_d;

    fc_req_t [FC_NUM_CANDS-1:0] cand_req;
    logic [FC_NUM_TYPES-1:0]    init_seen;
    logic [FC_NUM_TYPES-1:0][FC_NUM_CANDS-1:0] pass_by_type;
    logic [FC_NUM_CANDS-1:0]    cand_pass;
    logic                       grant_valid;
    logic                       grant_sel;
    fc_type_t                   grant_type;
    logic [FC_DREQ_W-1:0]       grant_data;
    logic                       active;

    assign cand_req[0] = fc_decode(Command_1, PTLP_1);
    assign cand_req[1] = fc_decode(Command_2, PTLP_2);
    assign active      = (state_q == S_ACTIVE);

    genvar gi, gc;
    generate
        for (gi = 0; gi < FC_NUM_TYPES; gi++) begin : g_type
            localparam logic [1:0] TYPE_ID = 2'(gi);
            logic [FC_NUM_CANDS-1:0] hit;
            logic                    type_sel;
            logic                    consume;

            for (gc = 0; gc < FC_NUM_CANDS; gc++) begin : g_hit
                assign hit[gc] = cand_req[gc].valid &&
                                 (cand_req[gc].ftype == fc_type_t'(TYPE_ID));
            end

            assign type_sel      = (DLL_FC_type == fc_type_t'(TYPE_ID));
            assign init_seen[gi] = DLL_FC_valid && DLL_FC_init && type_sel;
            assign consume       = grant_valid && (grant_type == fc_type_t'(TYPE_ID));

            tx_fc_type_tracker #(
                .HDR_W  (FC_HDR_WIDTH),
                .DATA_W (FC_DATA_WIDTH)
            ) u_tracker (
                .clk            (clk),
                .rst            (rst),
                .init_i         (init_seen[gi]),
                .update_i       (DLL_FC_valid && !DLL_FC_init && type_sel && active),
                .hdr_val_i      (DLL_FC_hdr),
                .data_val_i     (DLL_FC_data),
                .hit_i          (hit),
                .data_req_i     ({cand_req[1].data_req, cand_req[0].data_req}),
                .consume_i      (consume),
                .consume_data_i (grant_data),
                .pass_o         (pass_by_type[gi])
            );
        end
    endgenerate

    always_comb begin
        cand_pass = '0;
        for (int t = 0; t < FC_NUM_TYPES; t++) begin
            cand_pass = cand_pass | pass_by_type[t];
        end
    end

    // Candidate 1 has fixed priority; nothing is granted before init completes.
    always_comb begin
        result_d    = FC_FAILED;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (active) begin
            if (cand_pass[0]) begin
                result_d    = FC_SUCCESS_1;
                grant_valid = 1'b1;
            end else if (cand_pass[1]) begin
                result_d    = FC_SUCCESS_2;
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    assign grant_type = cand_req[grant_sel].ftype;
    assign grant_data = cand_req[grant_sel].data_req;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_mask_q <= '0;
            result_q    <= FC_FAILED;
        end else begin
            state_q     <= state_d;
            init_mask_q <= init_mask_d;
            result_q    <= result_d;
        end
    end

    // Next-state logic: the InitFC arriving this cycle counts toward completion.
    always_comb begin
        init_mask_d = init_mask_q | init_seen;
        state_d     = state_q;
        case (state_q)
            S_INIT:   if (&init_mask_d) state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_ACTIVE;
            default:  state_d = S_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        FC_ready = (state_q == S_ACTIVE);
        Result   = result_q;
    end

endmodule

// File: tb/tb_tx_fc_credit_gate.sv
// Randomized and directed bench for tx_fc_credit_gate against a credit model
// kept as plain integer arithmetic on limits and consumed counts.
module tb_tx_fc_credit_gate;
    import Tx_Arbiter_Package::*;

    localparam longint HMOD = 4096;
    localparam longint DMOD = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ptlp1, ptlp2;
    FC_command_t cmd1, cmd2;
    FC_result_t  result;
    logic        dll_valid, dll_init;
    fc_type_t    dll_type;
    logic [11:0] dll_hdr;
    logic [15:0] dll_data;
    logic        fc_ready;

    int n_checks = 0;
    int n_errors = 0;

    tx_fc_credit_gate #(.FC_HDR_WIDTH(12), .FC_DATA_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .PTLP_1       (ptlp1),
        .PTLP_2       (ptlp2),
        .Command_1    (cmd1),
        .Command_2    (cmd2),
        .Result       (result),
        .DLL_FC_valid (dll_valid),
        .DLL_FC_init  (dll_init),
        .DLL_FC_type  (dll_type),
        .DLL_FC_hdr   (dll_hdr),
        .DLL_FC_data  (dll_data),
        .FC_ready     (fc_ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint     m_cl_h[3], m_cl_d[3], m_cc_h[3], m_cc_d[3];
    bit         m_inf_h[3], m_inf_d[3], m_seen[3];
    bit         m_active;
    FC_result_t exp_result;
    bit         exp_ready;

    function automatic int cmd_kind(FC_command_t c);
        return (int'(c) - 1) / 2;
    endfunction

    function automatic longint cmd_data(FC_command_t c, int len);
        if (c == FC_NOP || ((int'(c) - 1) % 2) == 0) return 0;
        if (len == 0) return 256;
        return (len + 3) / 4;
    endfunction

    function automatic bit field_ok(longint cl, longint cc, longint need, longint mod);
        longint left;
        left = ((cl - cc - need) % mod + mod) % mod;
        return left <= mod / 2;
    endfunction

    function automatic bit m_pass(FC_command_t c, int len);
        int t;
        if (c == FC_NOP) return 0;
        t = cmd_kind(c);
        return (m_inf_h[t] || field_ok(m_cl_h[t], m_cc_h[t], 1, HMOD)) &&
               (m_inf_d[t] || field_ok(m_cl_d[t], m_cc_d[t], cmd_data(c, len), DMOD));
    endfunction

    task automatic model_edge();
        FC_command_t gc;
        int          glen, t;
        bit          granted;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cl_h[i] = 0; m_cl_d[i] = 0; m_cc_h[i] = 0; m_cc_d[i] = 0;
                m_inf_h[i] = 0; m_inf_d[i] = 0; m_seen[i] = 0;
            end
            m_active = 0; exp_result = FC_FAILED; exp_ready = 0;
            return;
        end
        exp_result = FC_FAILED; granted = 0; gc = FC_NOP; glen = 0;
        if (m_active) begin
            if (m_pass(cmd1, int'(ptlp1))) begin
                exp_result = FC_SUCCESS_1; granted = 1; gc = cmd1; glen = int'(ptlp1);
            end else if (m_pass(cmd2, int'(ptlp2))) begin
                exp_result = FC_SUCCESS_2; granted = 1; gc = cmd2; glen = int'(ptlp2);
            end
        end
        if (granted) begin
            t = cmd_kind(gc);
            if (!m_inf_h[t]) m_cc_h[t] = (m_cc_h[t] + 1) % HMOD;
            if (!m_inf_d[t]) m_cc_d[t] = (m_cc_d[t] + cmd_data(gc, glen)) % DMOD;
        end
        if (dll_valid && int'(dll_type) < 3) begin
            t = int'(dll_type);
            if (dll_init) begin
                m_cl_h[t] = dll_hdr;  m_inf_h[t] = (dll_hdr == 0);
                m_cl_d[t] = dll_data; m_inf_d[t] = (dll_data == 0);
                m_seen[t] = 1;
            end else if (m_active) begin
                if (!m_inf_h[t]) m_cl_h[t] = dll_hdr;
                if (!m_inf_d[t]) m_cl_d[t] = dll_data;
            end
        end
        if (m_seen[0] && m_seen[1] && m_seen[2]) m_active = 1;
        exp_ready = m_active;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cmd1 = FC_NOP; cmd2 = FC_NOP; ptlp1 = '0; ptlp2 = '0;
        dll_valid = 0; dll_init = 0; dll_type = FC_TYPE_P; dll_hdr = '0; dll_data = '0;
    endtask

    task automatic dll(input bit init, input int t, input int h, input int d);
        dll_valid = 1; dll_init = init; dll_type = fc_type_t'(t);
        dll_hdr = 12'(h); dll_data = 16'(d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); rst = 1;
        step(); step();
        n_checks++;
        if (result !== FC_FAILED) begin
            n_errors++; $display("FAIL reset_result got %0d want %0d", result, FC_FAILED);
        end
        n_checks++;
        if (fc_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_ready got %b want 0", fc_ready);
        end
        rst = 0;
        $display("reset done result=%0d ready=%b", result, fc_ready);
    endtask

    task automatic test_init();
        int hv[3] = '{2, 1, 0};
        int dv[3] = '{8, 0, 0};
        cmd1 = FC_P_H; cmd2 = FC_CPL_H;
        for (int i = 0; i < 3; i++) begin
            dll(1, i, hv[i], dv[i]);
            step();
            n_checks++;
            if (result !== FC_FAILED) begin
                n_errors++; $display("FAIL init_result[%0d] got %0d want %0d", i, result, FC_FAILED);
            end
            n_checks++;
            if (fc_ready !== (i == 2)) begin
                n_errors++; $display("FAIL init_ready[%0d] got %b want %b", i, fc_ready, (i == 2));
            end
            $display("initfc type=%0d hdr=%0d data=%0d ready=%b", i, hv[i], dv[i], fc_ready);
        end
        idle(); cmd1 = FC_CPL_HD; ptlp1 = 10'd0;
        step();
        n_checks++;
        if (result !== FC_SUCCESS_1) begin
            n_errors++; $display("FAIL cpl_infinite got %0d want %0d", result, FC_SUCCESS_1);
        end
        $display("cpl_hd len=1024 result=%0d", result);
    endtask

    task automatic test_p_data_exhaust();
        FC_result_t want[3] = '{FC_SUCCESS_1, FC_SUCCESS_1, FC_FAILED};
        idle(); cmd1 = FC_P_HD; ptlp1 = 10'd16;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (result !== want[i]) begin
                n_errors++; $display("FAIL p_exhaust[%0d] got %0d want %0d", i, result, want[i]);
            end
            $display("p_hd len=16 #%0d result=%0d", i, result);
        end
    endtask

    task automatic test_cand2();
        idle(); cmd1 = FC_NP_H;
        step();
        n_checks++;
        if (result !== FC_SUCCESS_1) begin
            n_errors++; $display("FAIL np_first got %0d want %0d", result, FC_SUCCESS_1);
        end
        cmd2 = FC_CPL_HD; ptlp2 = 10'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (result !== FC_SUCCESS_2) begin
                n_errors++; $display("FAIL cand2[%0d] got %0d want %0d", i, result, FC_SUCCESS_2);
            end
            $display("np_h + cpl_hd #%0d result=%0d", i, result);
        end
    endtask

    task automatic test_update_same_edge();
        idle(); cmd1 = FC_P_HD; ptlp1 = 10'd16;
        dll(0, 0, 3, 12);
        step();
        n_checks++;
        if (result !== FC_FAILED) begin
            n_errors++; $display("FAIL upd_same_edge got %0d want %0d", result, FC_FAILED);
        end
        dll_valid = 0;
        step();
        n_checks++;
        if (result !== FC_SUCCESS_1) begin
            n_errors++; $display("FAIL upd_after got %0d want %0d", result, FC_SUCCESS_1);
        end
        $display("updatefc p data=12 then result=%0d", result);
    endtask

    task automatic run_p_until(input longint target);
        int n = 0;
        idle(); cmd1 = FC_P_H;
        while (m_cc_h[0] != target && n < 5000) begin
            step(); n++;
            n_checks++;
            if (result !== exp_result) begin
                n_errors++; $display("FAIL wrap_run got %0d want %0d", result, exp_result);
            end
        end
        n_checks++;
        if (m_cc_h[0] != target) begin
            n_errors++; $display("FAIL wrap_budget got cc %0d want %0d", m_cc_h[0], target);
        end
        $display("p_h run %0d grants, cc_hdr=%0h", n, m_cc_h[0]);
    endtask

    task automatic test_hdr_wrap();
        FC_result_t want[3] = '{FC_SUCCESS_1, FC_SUCCESS_1, FC_FAILED};
        idle(); dll(0, 0, 12'h7FF, int'(m_cl_d[0])); step();
        run_p_until(12'h7FF);
        idle(); dll(0, 0, 12'hFFF, int'(m_cl_d[0])); step();
        run_p_until(12'hFFF);
        idle(); dll(0, 0, 12'h001, int'(m_cl_d[0])); step();
        idle(); cmd1 = FC_P_H;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (result !== want[i]) begin
                n_errors++; $display("FAIL hdr_wrap[%0d] got %0d want %0d", i, result, want[i]);
            end
            $display("p_h wrap #%0d result=%0d", i, result);
        end
    endtask

    task automatic random_cycle();
        int t;
        cmd1  = FC_command_t'($urandom_range(0, 6));
        cmd2  = FC_command_t'($urandom_range(0, 6));
        ptlp1 = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 64));
        ptlp2 = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 64));
        dll_valid = 0;
        if ($urandom_range(0, 3) == 0) begin
            t = $urandom_range(0, 2);
            dll($urandom_range(0, 15) == 0, t,
                int'((m_cc_h[t] + $urandom_range(0, 4)) % HMOD),
                int'((m_cc_d[t] + $urandom_range(0, 40)) % DMOD));
        end
    endtask

    task automatic test_random();
        int errs0 = n_errors;
        for (int i = 0; i < 1500; i++) begin
            random_cycle();
            step();
            n_checks++;
            if (result !== exp_result) begin
                n_errors++; $display("FAIL rand_result[%0d] got %0d want %0d", i, result, exp_result);
            end
            n_checks++;
            if (fc_ready !== exp_ready) begin
                n_errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, fc_ready, exp_ready);
            end
        end
        $display("random traffic 1500 cycles, new errors %0d", n_errors - errs0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin random_cycle(); step(); end
        cmd1 = FC_CPL_H; rst = 1; dll(0, 0, 100, 100);
        step();
        rst = 0;
        n_checks++;
        if (result !== FC_FAILED) begin
            n_errors++; $display("FAIL midrst_result got %0d want %0d", result, FC_FAILED);
        end
        n_checks++;
        if (fc_ready !== 1'b0) begin
            n_errors++; $display("FAIL midrst_ready got %b want 0", fc_ready);
        end
        for (int i = 0; i < 4; i++) begin
            random_cycle();
            if (cmd1 == FC_NOP) cmd1 = FC_CPL_H;
            dll_init = 0;
            step();
            n_checks++;
            if (result !== FC_FAILED || fc_ready !== 1'b0) begin
                n_errors++; $display("FAIL midrst_hold[%0d] got %0d/%b want %0d/0", i, result, fc_ready, FC_FAILED);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin dll(1, i, 4, 64); step(); end
        idle(); cmd1 = FC_P_HD; ptlp1 = 10'd16;
        step();
        n_checks++;
        if (result !== FC_SUCCESS_1) begin
            n_errors++; $display("FAIL reinit got %0d want %0d", result, FC_SUCCESS_1);
        end
        $display("mid-traffic reset then re-init result=%0d ready=%b", result, fc_ready);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle();
        test_reset();
        test_init();
        test_p_data_exhaust();
        test_cand2();
        test_update_same_edge();
        test_hdr_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_fc_credit_gate.md
TX_FC_CREDIT_GATE -- requirements
Module: tx_fc_credit_gate

Interface
REQ-001 SHALL have parameter FC_HDR_WIDTH, default 12, header credit counter width.
REQ-002 SHALL have parameter FC_DATA_WIDTH, default 16, data credit counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port PTLP_1  in  10  candidate-1 payload length in DW (0 = 1024 DW).
REQ-007 SHALL have port PTLP_2  in  10  candidate-2 payload length in DW (0 = 1024 DW).
REQ-008 SHALL have port Command_1  in  FC_command_t  candidate-1 request: FC_NOP, FC_P_H, FC_P_HD, FC_NP_H, FC_NP_HD, FC_CPL_H, FC_CPL_HD.
REQ-009 SHALL have port Command_2  in  FC_command_t  candidate-2 request, same encoding.
REQ-010 SHALL have port Result  out  FC_result_t  FC_FAILED, FC_SUCCESS_1 or FC_SUCCESS_2.
REQ-011 SHALL have port DLL_FC_valid  in  1  FC DLLP received from the data link layer.
REQ-012 SHALL have port DLL_FC_init  in  1  1 = InitFC, 0 = UpdateFC.
REQ-013 SHALL have port DLL_FC_type  in  fc_type_t  FC_TYPE_P, FC_TYPE_NP or FC_TYPE_CPL.
REQ-014 SHALL have port DLL_FC_hdr  in  FC_HDR_WIDTH  advertised header credit limit.
REQ-015 SHALL have port DLL_FC_data  in  FC_DATA_WIDTH  advertised data credit limit.
REQ-016 SHALL have port FC_ready  out  1  high once all three types are initialized.

Function
REQ-017 SHALL implement FSM S_INIT -> S_ACTIVE; the transition fires on the edge after InitFC has been seen for all three types; it never returns to S_INIT except through reset.
REQ-018 SHALL drive Result = FC_FAILED and FC_ready = 0 throughout S_INIT; no credits are consumed there.
REQ-019 SHALL on InitFC load CL_hdr/CL_data of that type; a loaded value of 0 SHALL set that field's infinite flag.
REQ-020 SHALL on UpdateFC overwrite CL of that type (no add); fields flagged infinite SHALL ignore updates; UpdateFC in S_INIT SHALL be ignored.
REQ-021 SHALL map header requirement = 1 for every non-NOP command; data requirement = 0 for *_H, and ceil(PTLP/4) for *_HD with PTLP = 0 giving 256.
REQ-022 SHALL pass a field when its flag is infinite or ((CL - (CC + req)) mod 2^W) <= 2^(W-1), W = field width; a candidate passes when both fields pass; FC_NOP never passes.
REQ-023 SHALL register Result one cycle after the commands are sampled: candidate 1 passes -> FC_SUCCESS_1; else candidate 2 passes -> FC_SUCCESS_2; else FC_FAILED.
REQ-024 SHALL on the same edge that registers FC_SUCCESS_x add the granted candidate's requirements to CC_hdr/CC_data of its type, modulo 2^W, so the next cycle's check sees the updated CC.
REQ-025 SHALL apply CL update and CC consumption on the same edge independently when both target the same type; the grant decision uses pre-edge CL.
REQ-026 SHALL consume for at most one candidate per cycle, even if both pass.

Reset
REQ-027 SHALL on rst: state = S_INIT, all CL/CC = 0, infinite flags = 0, init mask = 0, Result = FC_FAILED, FC_ready = 0.
REQ-028 SHALL give reset priority over a simultaneous DLL_FC_valid or grant; mid-operation reset discards all credit state.

Structure
REQ-029 SHALL take FC_command_t, FC_result_t, fc_type_t and the FC state enum from Tx_Arbiter_Package.
REQ-030 SHALL instantiate sub-module tx_fc_type_tracker three times (P, NP, CPL), each holding CL, CC, infinite flags and the pass compare for both candidates.

Verification
REQ-031 SHALL cover: InitFC P(hdr 2, data 8), NP(1, 0), CPL(0, 0) -> FC_ready rises the cycle after the third; CPL infinite on both fields.
REQ-032 SHALL cover: after REQ-031, Command_1 = FC_P_HD, PTLP_1 = 16, three cycles -> SUCCESS_1, SUCCESS_1, FAILED (data exhausted at CC = 8).
REQ-033 SHALL cover: Command_1 = FC_NP_H with NP hdr exhausted, Command_2 = FC_CPL_HD, PTLP_2 = 0 -> FC_SUCCESS_2 and CPL CC unchanged (infinite).
REQ-034 SHALL cover: P CC_hdr = 0xFFF, CL_hdr = 0x001 -> grant passes and CC_hdr wraps to 0x000; next request passes (CL = 1, CC = 0).
REQ-035 SHALL cover: UpdateFC P data = 12 on the same edge as a FAILED P request -> the following cycle returns FC_SUCCESS_1.
REQ-036 SHALL cover: rst asserted mid-traffic -> next cycle Result = FC_FAILED, FC_ready = 0, and requests fail until re-initialized.
